s2p_rx: RTL and testbench
=========================

# s2p_rx

Serial-to-parallel receiver that sits directly downstream of the p2s serializer. It consumes the serializer's one-bit `data_out` stream and its `sync` frame marker, and reassembles MSB-first WIDTH-bit words. Completed words go into a small output FIFO with a valid/ready handshake toward the consumer. Malformed framing and FIFO overflow are flagged with single-cycle pulses.

## Interface
- `WIDTH`, default 8: bits per frame and output word width.
- `DEPTH`, default 2: output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial bit, MSB first, one bit per cycle.
- `sync`  in  1  high in the cycle carrying the MSB of a frame.
- `data_out`  out  WIDTH  word at FIFO head; 0 when FIFO empty.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts `data_out` when `valid && ready`.
- `overflow`  out  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: `sync` arrived before the current frame completed.

## Operation
- Deserializer state machine with two states, IDLE and SHIFT, plus bit counter `cnt` (0..WIDTH) and shift register `sh`.
- IDLE:
  - `data_in` is ignored unless `sync` = 1.
  - On `sync`: `sh <= {sh, data_in}`, `cnt <= 1`, go to SHIFT.
- SHIFT, `sync` = 0:
  - Shift `data_in` into the LSB; `cnt <= cnt + 1`.
  - When the shift makes `cnt` reach WIDTH: push the assembled word, return to IDLE, `cnt <= 0`.
- SHIFT, `sync` = 1:
  - Pulse `frame_err`.
  - Discard the partial word and restart with this bit as the MSB (`cnt <= 1`, stay in SHIFT). No push occurs.
- Back-to-back frames: `sync` in the cycle immediately after a frame's last bit is legal. IDLE handles it; no gap is required and no error is raised.
- FIFO:
  - Circular buffer of DEPTH entries with separate read/write pointers and a count of width log2(DEPTH)+1.
  - Pop when `valid && ready`.
  - Push when a frame completes.
  - Push to a full FIFO: the word is dropped, `overflow` pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: only the push occurs. There is no fall-through, because `valid` is 0 that cycle.
- `data_out` is the head entry when `valid` = 1, and 0 otherwise.

## Timing
- Reset (async assert, sync-to-clock deassert is the system's job) forces:
  - state IDLE, `cnt` 0, `sh` 0
  - FIFO empty, pointers 0
  - `data_out` 0, `valid` 0, `overflow` 0, `frame_err` 0
- Reset mid-frame: the partial word is lost and no push occurs. The first `sync` after release starts a fresh frame.
- Latency: the last bit is sampled at edge E. The word is written at E, and `valid` and `data_out` are valid immediately after E. Total: WIDTH cycles from the `sync` edge to `valid`.
- Throughput: one word per WIDTH cycles sustained, with `ready` held high.
- `overflow` and `frame_err` are registered. Each is high for exactly the one cycle after the triggering edge.
- `valid` and `data_out` change only on clock edges. `ready` may change freely; it is sampled at the edge.

## Test plan
- Single frame: `sync` + bits 1,1,1,0,0,1,1,1 (0xE7), `ready` = 1.
  - `valid` rises exactly 8 cycles after the `sync` edge with `data_out` = 0xE7.
  - `valid` falls the next cycle.
  - No flags.
- Back-to-back frames: 0xE7 then immediately 0x83 (second `sync` in the cycle after the first frame's last bit), `ready` = 1.
  - Words are received in order, 8 cycles apart.
  - `frame_err` stays 0.
- Backpressure/overflow: `ready` = 0, send 0xE7, 0x83, 0x5A.
  - The first two are held.
  - `overflow` pulses once after the 0x5A frame's last bit.
  - Raising `ready` pops 0xE7 then 0x83, then `valid` = 0.
- Early sync: `sync` + 4 bits, then `sync` + a full 0x3C frame.
  - `frame_err` pulses once.
  - The only output word is 0x3C.
- Full with simultaneous push/pop: with the FIFO holding 0xE7,0x83, assert `ready` in the cycle frame 0xA5 completes.
  - No overflow.
  - Subsequent output order is 0x83, 0xA5.
- Reset mid-frame: assert `reset_n` = 0 after 3 bits.
  - All outputs are 0 asynchronously.
  - After release, a clean 0x81 frame produces exactly 0x81.

Source files
------------

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: rebuilds MSB-first WIDTH-bit frames delimited by sync
// and queues finished words in a small valid/ready output FIFO.
module s2p_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    output logic             frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             push;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop, full, wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sync) state_d = SHIFT;
            SHIFT:   if (!sync && cnt_q == CW'(WIDTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The word pushed on completion is sh_d, i.e. it already contains the last bit.
    always_comb begin
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    sh_d  = {sh_q[WIDTH-2:0], data_in};
                    cnt_d = CW'(1);
                end
            end
            SHIFT: begin
                sh_d = {sh_q[WIDTH-2:0], data_in};
                if (sync) begin
                    frame_err_d = 1'b1;
                    cnt_d       = CW'(1);
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    push  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign valid = (count_q != '0);
    assign pop   = valid && ready;
    assign full  = (count_q == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = sh_d;
        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        overflow_d = push && full && !pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            sh_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            mem_q       <= mem_d;
        end
    end

    assign data_out  = valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx: hand-computed frames, popped words logged by a
// posedge monitor together with flag pulse counts.
module tb_s2p_rx;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       data_in;
    logic       sync;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] got_q [$];
    int         got_cyc [$];
    int         ovf_cnt  = 0;
    int         ferr_cnt = 0;
    int         cyc      = 0;

    s2p_rx #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .sync      (sync),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Values read here are the pre-edge ones, i.e. what the edge acts on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid && ready) begin
            got_q.push_back(data_out);
            got_cyc.push_back(cyc);
        end
        if (overflow)  ovf_cnt  <= ovf_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic d);
        sync    = s;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) step(i == 7, w[i]);
        sync    = 1'b0;
        data_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
        ovf_cnt  = 0;
        ferr_cnt = 0;
    endtask

    initial begin
        logic [7:0] w;
        reset_n = 1'b0;
        sync    = 1'b0;
        data_in = 1'b0;
        ready   = 1'b0;
        #3;
        chk("reset valid", valid, 0);
        chk("reset data_out", data_out, 0);
        chk("reset overflow", overflow, 0);
        chk("reset frame_err", frame_err, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);

        // Single frame 0xE7: valid only after the 8th edge
        clear_log();
        ready = 1'b1;
        w = 8'hE7;
        for (int i = 0; i < 8; i++) begin
            step(i == 0, w[7-i]);
            chk($sformatf("single valid@%0d", i), valid, (i == 7));
        end
        chk("single data_out", data_out, 8'hE7);
        idle(1);
        chk("single valid falls", valid, 0);
        chk("single data_out empty", data_out, 0);
        chk("single words", got_q.size(), 1);
        chk("single flags", ovf_cnt + ferr_cnt, 0);

        // Back-to-back frames
        clear_log();
        send_frame(8'hE7);
        send_frame(8'h83);
        idle(2);
        chk("b2b words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b word0", got_q[0], 8'hE7);
            chk("b2b word1", got_q[1], 8'h83);
            chk("b2b spacing", got_cyc[1] - got_cyc[0], 8);
        end
        chk("b2b frame_err", ferr_cnt, 0);

        // Backpressure and overflow
        clear_log();
        ready = 1'b0;
        send_frame(8'hE7);
        send_frame(8'h83);
        send_frame(8'h5A);
        chk("bp overflow pulse", overflow, 1);
        idle(1);
        chk("bp overflow cleared", overflow, 0);
        chk("bp held valid", valid, 1);
        chk("bp head", data_out, 8'hE7);
        ready = 1'b1;
        idle(3);
        chk("bp overflow count", ovf_cnt, 1);
        chk("bp words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("bp word0", got_q[0], 8'hE7);
            chk("bp word1", got_q[1], 8'h83);
        end
        chk("bp drained", valid, 0);

        // Early sync aborts the partial frame
        clear_log();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        send_frame(8'h3C);
        idle(2);
        chk("early frame_err count", ferr_cnt, 1);
        chk("early words", got_q.size(), 1);
        if (got_q.size() == 1) chk("early word0", got_q[0], 8'h3C);
        chk("early overflow", ovf_cnt, 0);

        // Full FIFO with push and pop on the same edge
        clear_log();
        ready = 1'b0;
        send_frame(8'hE7);
        send_frame(8'h83);
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ready = 1'b1;
            step(i == 0, w[7-i]);
        end
        ready = 1'b0;
        chk("full overflow", overflow, 0);
        chk("full head", data_out, 8'h83);
        ready = 1'b1;
        idle(3);
        chk("full overflow count", ovf_cnt, 0);
        chk("full words", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("full word0", got_q[0], 8'hE7);
            chk("full word1", got_q[1], 8'h83);
            chk("full word2", got_q[2], 8'hA5);
        end

        // Asynchronous reset mid-frame with a word held in the FIFO
        clear_log();
        ready = 1'b0;
        send_frame(8'hE7);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("pre-reset valid", valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset valid", valid, 0);
        chk("async reset data_out", data_out, 0);
        chk("async reset overflow", overflow, 0);
        chk("async reset frame_err", frame_err, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        ready   = 1'b1;
        clear_log();
        send_frame(8'h81);
        chk("post-reset data_out", data_out, 8'h81);
        idle(2);
        chk("post-reset words", got_q.size(), 1);
        if (got_q.size() == 1) chk("post-reset word0", got_q[0], 8'h81);
        chk("post-reset flags", ovf_cnt + ferr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
